axi_tdd_sync_gen: RTL and testbench

Sync scheduler for the TDD counter core. It merges an internal periodic timer, an external sync input and a software sync request into one single-cycle `tdd_sync` pulse stream. It supports continuous and one-shot modes, and realigns the internal timer to every external or software sync. It sits between the register map / external sync pin and the `tdd_sync` input of the TDD counter.

---
 rtl/axi_tdd_sync_gen.sv | 129 ++++++++++++
 tb/tb_axi_tdd_sync_gen.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_tdd_sync_gen.sv
// Merges internal periodic timer, external sync pin and software sync into one tdd_sync pulse stream.
// Latency: soft 1 cycle, external 1 cycle (+2 with the CDC synchronizer), internal P cycles from ACTIVE.
// Backpressure: none; events are pulses and events outside ACTIVE are dropped.
module axi_tdd_sync_gen #(
    parameter int unsigned SYNC_COUNT_WIDTH = 32,
    parameter bit          EXT_SYNC_CDC     = 1'b1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        sync_en,
    input  logic                        sync_int_en,
    input  logic                        sync_ext_en,
    input  logic                        sync_oneshot,
    input  logic                        sync_soft,
    input  logic                        sync_in,
    input  logic [SYNC_COUNT_WIDTH-1:0] sync_period,
    output logic                        tdd_sync,
    output logic [31:0]                 sync_count,
    output logic [1:0]                  sync_state
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    localparam logic [SYNC_COUNT_WIDTH-1:0] CNT_ONE = SYNC_COUNT_WIDTH'(1);

    state_t                      state_q, state_d;
    logic [SYNC_COUNT_WIDTH-1:0] tmr_q, tmr_d;
    logic                        ext_prev_q, ext_prev_d;
    logic                        soft_prev_q, soft_prev_d;
    logic                        tdd_sync_q, tdd_sync_d;
    logic [31:0]                 sync_count_q, sync_count_d;

    logic                        ext_lvl;
    logic                        ext_evt, soft_evt, int_evt, int_on, any_evt, emit;
    logic [SYNC_COUNT_WIDTH-1:0] period_m1;

    generate
        if (EXT_SYNC_CDC) begin : g_cdc
            logic meta_q, meta_d;
            logic sync2_q, sync2_d;

            always_comb begin
                meta_d  = sync_in;
                sync2_d = meta_q;
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    meta_q  <= 1'b0;
                    sync2_q <= 1'b0;
                end else begin
                    meta_q  <= meta_d;
                    sync2_q <= sync2_d;
                end
            end

            assign ext_lvl = sync2_q;
        end else begin : g_no_cdc
            assign ext_lvl = sync_in;
        end
    endgenerate

    always_comb begin
        ext_prev_d  = ext_lvl;
        soft_prev_d = sync_soft;
        period_m1   = sync_period - CNT_ONE;

        ext_evt  = ext_lvl & ~ext_prev_q & sync_ext_en;
        soft_evt = sync_soft & ~soft_prev_q;
        int_on   = sync_int_en && (sync_period != '0);
        // >= rather than == so a period shrunk below the current count fires at once
        int_evt  = int_on && (tmr_q >= period_m1);
        any_evt  = int_evt | ext_evt | soft_evt;
        emit     = (state_q == ST_ACTIVE) && any_evt;

        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (sync_en) state_d = ST_ACTIVE;
            ST_ACTIVE: begin
                if (!sync_en)                  state_d = ST_IDLE;
                else if (emit && sync_oneshot) state_d = ST_DONE;
            end
            ST_DONE:   if (!sync_en) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase

        // Any emitted event (including ext/soft realignment) restarts the period
        tmr_d = '0;
        if ((state_q == ST_ACTIVE) && (state_d == ST_ACTIVE) && int_on && !any_evt) begin
            tmr_d = tmr_q + CNT_ONE;
        end

        tdd_sync_d = emit;

        sync_count_d = sync_count_q;
        if ((state_q == ST_IDLE) && (state_d == ST_ACTIVE)) begin
            sync_count_d = 32'd0;
        end else if (emit) begin
            sync_count_d = sync_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            tmr_q        <= '0;
            ext_prev_q   <= 1'b0;
            soft_prev_q  <= 1'b0;
            tdd_sync_q   <= 1'b0;
            sync_count_q <= 32'd0;
        end else begin
            state_q      <= state_d;
            tmr_q        <= tmr_d;
            ext_prev_q   <= ext_prev_d;
            soft_prev_q  <= soft_prev_d;
            tdd_sync_q   <= tdd_sync_d;
            sync_count_q <= sync_count_d;
        end
    end

    assign tdd_sync   = tdd_sync_q;
    assign sync_count = sync_count_q;
    assign sync_state = state_q;

endmodule

// File: tb/tb_axi_tdd_sync_gen.sv
// Directed bench for axi_tdd_sync_gen: inputs change and outputs are sampled on the falling edge.
// Cycle k of a scenario is the cycle after the k-th rising edge from the point sync_en is driven.
module tb_axi_tdd_sync_gen;

    logic        clk;
    logic        rst;
    logic        sync_en;
    logic        sync_int_en;
    logic        sync_ext_en;
    logic        sync_oneshot;
    logic        sync_soft;
    logic        sync_in;
    logic [31:0] sync_period;
    logic        tdd_sync;
    logic [31:0] sync_count;
    logic [1:0]  sync_state;

    int n_checks = 0;
    int n_fail   = 0;

    axi_tdd_sync_gen #(
        .SYNC_COUNT_WIDTH(32),
        .EXT_SYNC_CDC    (1'b1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .sync_en     (sync_en),
        .sync_int_en (sync_int_en),
        .sync_ext_en (sync_ext_en),
        .sync_oneshot(sync_oneshot),
        .sync_soft   (sync_soft),
        .sync_in     (sync_in),
        .sync_period (sync_period),
        .tdd_sync    (tdd_sync),
        .sync_count  (sync_count),
        .sync_state  (sync_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic next_cycle();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        sync_en      = 1'b0;
        sync_int_en  = 1'b0;
        sync_ext_en  = 1'b0;
        sync_oneshot = 1'b0;
        sync_soft    = 1'b0;
        sync_in      = 1'b0;
        sync_period  = 32'd0;
        next_cycle();
        next_cycle();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (tdd_sync !== 1'b0) begin n_fail++; $display("FAIL reset_tdd_sync got %0b want 0", tdd_sync); end
        n_checks++;
        if (sync_count !== 32'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", sync_count); end
        n_checks++;
        if (sync_state !== 2'd0) begin n_fail++; $display("FAIL reset_state got %0d want 0", sync_state); end
    endtask

    task automatic test_periodic();
        logic exp;
        do_reset();
        sync_en = 1'b1; sync_int_en = 1'b1; sync_period = 32'd10;
        for (int k = 1; k <= 35; k++) begin
            next_cycle();
            exp = (k == 11) || (k == 21) || (k == 31);
            n_checks++;
            if (tdd_sync !== exp) begin n_fail++; $display("FAIL periodic_pulse cycle %0d got %0b want %0b", k, tdd_sync, exp); end
            if (k == 1) begin
                n_checks++;
                if (sync_state !== 2'd1) begin n_fail++; $display("FAIL periodic_state got %0d want 1", sync_state); end
            end
        end
        n_checks++;
        if (sync_count !== 32'd3) begin n_fail++; $display("FAIL periodic_count got %0d want 3", sync_count); end
    endtask

    task automatic test_realign();
        logic exp;
        do_reset();
        sync_en = 1'b1; sync_int_en = 1'b1; sync_ext_en = 1'b1; sync_period = 32'd10;
        for (int k = 1; k <= 40; k++) begin
            next_cycle();
            exp = (k == 8) || (k == 18) || (k == 28) || (k == 38);
            n_checks++;
            if (tdd_sync !== exp) begin n_fail++; $display("FAIL realign_pulse cycle %0d got %0b want %0b", k, tdd_sync, exp); end
            if (k == 5)  sync_in = 1'b1;
            if (k == 10) sync_in = 1'b0;
            if (k == 27) sync_soft = 1'b1;
            if (k == 29) sync_soft = 1'b0;
        end
        n_checks++;
        if (sync_count !== 32'd4) begin n_fail++; $display("FAIL realign_merge_count got %0d want 4", sync_count); end
    endtask

    task automatic test_oneshot();
        logic exp;
        do_reset();
        sync_en = 1'b1; sync_int_en = 1'b1; sync_oneshot = 1'b1; sync_period = 32'd5;
        for (int k = 1; k <= 56; k++) begin
            next_cycle();
            exp = (k == 6);
            n_checks++;
            if (tdd_sync !== exp) begin n_fail++; $display("FAIL oneshot_pulse cycle %0d got %0b want %0b", k, tdd_sync, exp); end
        end
        n_checks++;
        if (sync_state !== 2'd2) begin n_fail++; $display("FAIL oneshot_state got %0d want 2", sync_state); end
        n_checks++;
        if (sync_count !== 32'd1) begin n_fail++; $display("FAIL oneshot_count got %0d want 1", sync_count); end
        sync_en = 1'b0;
        next_cycle();
        n_checks++;
        if (sync_state !== 2'd0) begin n_fail++; $display("FAIL oneshot_idle_state got %0d want 0", sync_state); end
        n_checks++;
        if (sync_count !== 32'd1) begin n_fail++; $display("FAIL oneshot_idle_hold got %0d want 1", sync_count); end
        sync_en = 1'b1;
        for (int k = 58; k <= 66; k++) begin
            next_cycle();
            exp = (k == 63);
            n_checks++;
            if (tdd_sync !== exp) begin n_fail++; $display("FAIL oneshot_resume cycle %0d got %0b want %0b", k, tdd_sync, exp); end
            if (k == 58) begin
                n_checks++;
                if (sync_count !== 32'd0) begin n_fail++; $display("FAIL oneshot_count_clear got %0d want 0", sync_count); end
            end
        end
        n_checks++;
        if (sync_count !== 32'd1) begin n_fail++; $display("FAIL oneshot_resume_count got %0d want 1", sync_count); end
    endtask

    task automatic test_period_one();
        logic exp;
        do_reset();
        sync_en = 1'b1; sync_int_en = 1'b1; sync_period = 32'd1;
        for (int k = 1; k <= 10; k++) begin
            next_cycle();
            exp = (k >= 2);
            n_checks++;
            if (tdd_sync !== exp) begin n_fail++; $display("FAIL p1_pulse cycle %0d got %0b want %0b", k, tdd_sync, exp); end
        end
        n_checks++;
        if (sync_count !== 32'd9) begin n_fail++; $display("FAIL p1_count got %0d want 9", sync_count); end
    endtask

    task automatic test_period_zero();
        do_reset();
        sync_en = 1'b1; sync_int_en = 1'b1; sync_period = 32'd0;
        for (int k = 1; k <= 30; k++) begin
            next_cycle();
            n_checks++;
            if (tdd_sync !== 1'b0) begin n_fail++; $display("FAIL p0_pulse cycle %0d got %0b want 0", k, tdd_sync); end
        end
        n_checks++;
        if (sync_count !== 32'd0) begin n_fail++; $display("FAIL p0_count got %0d want 0", sync_count); end
    endtask

    task automatic test_shrink();
        logic exp;
        do_reset();
        sync_en = 1'b1; sync_int_en = 1'b1; sync_period = 32'd20;
        for (int k = 1; k <= 25; k++) begin
            next_cycle();
            exp = (k == 12) || (k == 16) || (k == 20) || (k == 24);
            n_checks++;
            if (tdd_sync !== exp) begin n_fail++; $display("FAIL shrink_pulse cycle %0d got %0b want %0b", k, tdd_sync, exp); end
            if (k == 11) sync_period = 32'd4;
        end
    endtask

    task automatic test_ext_held();
        do_reset();
        sync_ext_en = 1'b1; sync_in = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            next_cycle();
            if (k == 5) sync_en = 1'b1;
            n_checks++;
            if (tdd_sync !== 1'b0) begin n_fail++; $display("FAIL ext_held_pulse cycle %0d got %0b want 0", k, tdd_sync); end
        end
        n_checks++;
        if (sync_state !== 2'd1) begin n_fail++; $display("FAIL ext_held_state got %0d want 1", sync_state); end
    endtask

    task automatic test_ext_disabled();
        do_reset();
        sync_en = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            next_cycle();
            if (k == 3) sync_in = 1'b1;
            if (k == 5) sync_in = 1'b0;
            if (k == 7) sync_in = 1'b1;
            n_checks++;
            if (tdd_sync !== 1'b0) begin n_fail++; $display("FAIL ext_dis_pulse cycle %0d got %0b want 0", k, tdd_sync); end
        end
    endtask

    task automatic test_disable();
        logic exp;
        do_reset();
        sync_en = 1'b1; sync_int_en = 1'b1; sync_period = 32'd10;
        for (int k = 1; k <= 30; k++) begin
            next_cycle();
            exp = (k == 4) || (k == 14) || (k == 17);
            n_checks++;
            if (tdd_sync !== exp) begin n_fail++; $display("FAIL disable_pulse cycle %0d got %0b want %0b", k, tdd_sync, exp); end
            if (k == 17) begin
                n_checks++;
                if (sync_state !== 2'd0) begin n_fail++; $display("FAIL disable_state got %0d want 0", sync_state); end
            end
            if (k == 3)  sync_soft = 1'b1;
            if (k == 5)  sync_soft = 1'b0;
            if (k == 16) begin sync_soft = 1'b1; sync_en = 1'b0; end
        end
        n_checks++;
        if (sync_count !== 32'd3) begin n_fail++; $display("FAIL disable_count_hold got %0d want 3", sync_count); end
    endtask

    task automatic test_rst_mid();
        do_reset();
        sync_en = 1'b1; sync_int_en = 1'b1; sync_period = 32'd10;
        for (int k = 1; k <= 15; k++) next_cycle();
        n_checks++;
        if (sync_count !== 32'd1) begin n_fail++; $display("FAIL rst_mid_pre_count got %0d want 1", sync_count); end
        sync_soft = 1'b1;
        rst       = 1'b1;
        next_cycle();
        n_checks++;
        if (tdd_sync !== 1'b0) begin n_fail++; $display("FAIL rst_mid_tdd_sync got %0b want 0", tdd_sync); end
        n_checks++;
        if (sync_count !== 32'd0) begin n_fail++; $display("FAIL rst_mid_count got %0d want 0", sync_count); end
        n_checks++;
        if (sync_state !== 2'd0) begin n_fail++; $display("FAIL rst_mid_state got %0d want 0", sync_state); end
        rst = 1'b0;
        sync_en = 1'b0;
        next_cycle();
    endtask

    initial begin
        test_reset();
        test_periodic();
        test_realign();
        test_oneshot();
        test_period_one();
        test_period_zero();
        test_shrink();
        test_ext_held();
        test_ext_disabled();
        test_disable();
        test_rst_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
